// File: rtl/qmem_checker_pkg.sv
// Shared definitions for the qmem protocol checker: FSM encoding and cause bit map.
package qmem_checker_pkg;

  // Transfer-tracking FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_STALL = 2'd2
  } qmem_state_e;

  // Sticky violation bit positions within cause
  localparam int unsigned CAUSE_W    = 4;
  localparam int unsigned CAUSE_TMO  = 0;
  localparam int unsigned CAUSE_STAB = 1;
  localparam int unsigned CAUSE_SPUR = 2;
  localparam int unsigned CAUSE_OVF  = 3;

endpackage

// File: rtl/qmem_trc_fifo.sv
// Synchronous first-word-fall-through FIFO holding qmem trace entries.
module qmem_trc_fifo #(
  parameter int unsigned W  = 70,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wr_data,
  output logic [W-1:0]  rd_data_c,
  output logic          valid,
  output logic          full,
  output logic [AW:0]   level
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;
  logic [AW:0]   level_d;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts push+pop
  assign do_pop  = pop & valid;
  assign do_push = push & (~full | do_pop);

  // Occupancy after this cycle's push/pop
  always_comb begin
    level_d = level;
    case ({do_push, do_pop})
      2'b10:   level_d = level + (AW+1)'(1);
      2'b01:   level_d = level - (AW+1)'(1);
      default: level_d = level;
    endcase
  end

  // Pointers, level and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      valid  <= 1'b0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_d;
      valid <= (level_d != '0);
      full  <= (level_d == (AW+1)'(DEPTH));
    end
  end

  // Entry storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data_c = mem[rd_ptr];

endmodule

// File: rtl/qmem_checker.sv
// Passive qmem bus monitor: transfer counters, protocol violation flags and a trace FIFO.
module qmem_checker
  import qmem_checker_pkg::*;
#(
  parameter int unsigned QAW    = 32,
  parameter int unsigned QDW    = 32,
  parameter int unsigned QSW    = QDW / 8,
  parameter int unsigned TMO_W  = 8,
  parameter int unsigned TRC_AW = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              we,
  input  logic              ack,
  input  logic              err,
  input  logic [QSW-1:0]    sel,
  input  logic [QAW-1:0]    adr,
  input  logic [QDW-1:0]    dat_w,
  input  logic [QDW-1:0]    dat_r,
  input  logic              enable,
  input  logic              clr,
  input  logic [TMO_W-1:0]  tmo_lim,
  input  logic              trc_pop,
  output logic              trc_valid,
  output logic              trc_we,
  output logic              trc_err,
  output logic [QSW-1:0]    trc_sel,
  output logic [QAW-1:0]    trc_adr,
  output logic [QDW-1:0]    trc_dat,
  output logic [TRC_AW:0]   trc_level,
  output logic [CNT_W-1:0]  r_cnt,
  output logic [CNT_W-1:0]  w_cnt,
  output logic [CNT_W-1:0]  e_cnt,
  output logic [CAUSE_W-1:0] cause,
  output logic              error
);

  localparam int unsigned TRC_W = 2 + QSW + QAW + QDW;

  qmem_state_e        state_q;
  qmem_state_e        state_d;
  logic [TMO_W-1:0]   wait_cnt_q;
  logic               busy;
  logic               wait_run;
  logic               tmo_hit;
  logic               trn;
  logic               stall_cyc;

  logic [QAW-1:0]     prev_adr;
  logic               prev_we;
  logic [QSW-1:0]     prev_sel;
  logic [QDW-1:0]     prev_dat_w;
  logic               stab_hit;
  logic               spur_hit;
  logic               ovf_hit;

  logic               pend_vld;
  logic               pend_we;
  logic               pend_err;
  logic [QSW-1:0]     pend_sel;
  logic [QAW-1:0]     pend_adr;
  logic [QDW-1:0]     pend_dat_w;
  logic [QDW-1:0]     push_dat;
  logic [TRC_W-1:0]   fifo_wr_data;
  logic [TRC_W-1:0]   fifo_rd_data;
  logic               fifo_full;

  logic [CAUSE_W-1:0] viol;
  logic [CAUSE_W-1:0] cause_d;
  logic               inc_r;
  logic               inc_w;
  logic               inc_e;

  assign trn       = cs & (ack | err);
  assign stall_cyc = cs & ~ack & ~err;

  // Saturating increment for the statistics counters
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
    return v;
  endfunction

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (stall_cyc)       state_d = ST_WAIT;
      ST_WAIT:  if (trn | ~cs)       state_d = ST_IDLE;
                else if (tmo_hit)    state_d = ST_STALL;
      ST_STALL: if (trn | ~cs)       state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; timeout only counts when this cycle is itself still stalled
  always_comb begin
    busy     = 1'b0;
    wait_run = 1'b0;
    tmo_hit  = 1'b0;
    case (state_q)
      ST_WAIT: begin
        busy     = 1'b1;
        wait_run = 1'b1;
        tmo_hit  = stall_cyc & (tmo_lim != '0) & (wait_cnt_q == tmo_lim);
      end
      ST_STALL: busy = 1'b1;
      default: ;
    endcase
  end

  // Wait counter: cleared in IDLE, saturating count of WAIT cycles, held in STALL
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else if (state_q == ST_IDLE) begin
      wait_cnt_q <= '0;
    end else if (wait_run && (wait_cnt_q != {TMO_W{1'b1}})) begin
      wait_cnt_q <= wait_cnt_q + TMO_W'(1);
    end
  end

  // Previous-cycle request attributes for stability checking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_adr   <= '0;
      prev_we    <= 1'b0;
      prev_sel   <= '0;
      prev_dat_w <= '0;
    end else begin
      prev_adr   <= adr;
      prev_we    <= we;
      prev_sel   <= sel;
      prev_dat_w <= dat_w;
    end
  end

  assign stab_hit = busy & cs & ((adr != prev_adr) | (we != prev_we) | (sel != prev_sel) |
                                 (we & (dat_w != prev_dat_w)));
  assign spur_hit = ~cs & (ack | err);
  // Overflow is not re-qualified by enable: the push was already admitted at transfer time
  assign ovf_hit  = pend_vld & fifo_full & ~(trc_pop & trc_valid);

  // Collect this cycle's violations
  always_comb begin
    viol             = '0;
    viol[CAUSE_TMO]  = enable & tmo_hit;
    viol[CAUSE_STAB] = enable & stab_hit;
    viol[CAUSE_SPUR] = enable & spur_hit;
    viol[CAUSE_OVF]  = ovf_hit;
    cause_d          = (clr ? '0 : cause) | viol;
  end

  // Sticky cause bits and their summary flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cause <= '0;
      error <= 1'b0;
    end else begin
      cause <= cause_d;
      error <= |cause_d;
    end
  end

  assign inc_w = enable & trn & we & ~err;
  assign inc_r = enable & trn & ~we & ~err;
  assign inc_e = enable & trn & err;

  // Transfer counters; a count in the clr cycle lands on the cleared value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      w_cnt <= '0;
      e_cnt <= '0;
    end else begin
      r_cnt <= bump(clr ? '0 : r_cnt, inc_r);
      w_cnt <= bump(clr ? '0 : w_cnt, inc_w);
      e_cnt <= bump(clr ? '0 : e_cnt, inc_e);
    end
  end

  // Pending trace entry captured at the transfer, pushed the following cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld   <= 1'b0;
      pend_we    <= 1'b0;
      pend_err   <= 1'b0;
      pend_sel   <= '0;
      pend_adr   <= '0;
      pend_dat_w <= '0;
    end else begin
      pend_vld <= enable & trn;
      if (enable && trn) begin
        pend_we    <= we;
        pend_err   <= err;
        pend_sel   <= sel;
        pend_adr   <= adr;
        pend_dat_w <= dat_w;
      end
    end
  end

  // Read data is only valid the cycle after ack, so it is taken live at push time
  assign push_dat     = pend_we ? pend_dat_w : dat_r;
  assign fifo_wr_data = {pend_we, pend_err, pend_sel, pend_adr, push_dat};

  qmem_trc_fifo #(
    .W  (TRC_W),
    .AW (TRC_AW)
  ) u_trc_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pend_vld),
    .pop       (trc_pop),
    .wr_data   (fifo_wr_data),
    .rd_data_c (fifo_rd_data),
    .valid     (trc_valid),
    .full      (fifo_full),
    .level     (trc_level)
  );

  assign {trc_we, trc_err, trc_sel, trc_adr, trc_dat} = fifo_rd_data;

endmodule

// File: doc/qmem_checker.md
QMEM_CHECKER -- requirements
Module: qmem_checker

Interface
REQ-001 Parameter QAW, default 32, qmem address width.
REQ-002 Parameter QDW, default 32, qmem data width.
REQ-003 Parameter QSW, default QDW/8, byte-select width.
REQ-004 Parameter TMO_W, default 8, timeout counter width.
REQ-005 Parameter TRC_AW, default 4, trace FIFO address width; depth = 2**TRC_AW.
REQ-006 Parameter CNT_W, default 32, statistics counter width.
REQ-007 clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-008 cs, we, ack, err  in  1 each  observed qmem control; sel in QSW; adr in QAW; dat_w, dat_r in QDW.
REQ-009 enable  in  1  monitoring enable; clr  in  1  synchronous clear of cause and counters.
REQ-010 tmo_lim  in  TMO_W  timeout limit in cycles; 0 disables timeout.
REQ-011 trc_pop  in  1  pop trace head; trc_valid  out  1  FIFO non-empty.
REQ-012 trc_we, trc_err  out  1 each; trc_sel  out  QSW; trc_adr  out  QAW; trc_dat  out  QDW: head entry (first-word-fall-through).
REQ-013 trc_level  out  TRC_AW+1  FIFO occupancy.
REQ-014 r_cnt, w_cnt, e_cnt  out  CNT_W each  read, write, err-terminated transfer counts.
REQ-015 cause  out  4  sticky violations {OVF,SPUR,STAB,TMO} bits 3..0; error  out  1  = OR of cause.

Function
REQ-016 Transfer trn = cs & (ack | err); only sampled when enable=1 in the trn cycle.
REQ-017 On trn: we=1 and err=0 increments w_cnt; we=0 and err=0 increments r_cnt; err=1 increments e_cnt only; all counters saturate at all-ones.
REQ-018 Trace entry pushed exactly one cycle after trn: adr, we, sel, err registered at trn; data = registered dat_w for writes, live dat_r (valid at ack+1) for reads.
REQ-019 At most one push per cycle; back-to-back trn cycles produce consecutive pushes in order.
REQ-020 Push when full (and no pop same cycle) drops the new entry and sets cause[3] OVF.
REQ-021 Push and pop in same cycle when full: both performed, level unchanged, no OVF.
REQ-022 trc_pop with trc_valid=0 is ignored; pointers wrap modulo depth.
REQ-023 FSM states IDLE, WAIT, STALL: IDLE->WAIT on cs & !ack & !err; WAIT->IDLE on trn or cs=0; WAIT->STALL when wait count == tmo_lim != 0 (sets cause[0] TMO); STALL->IDLE on trn or cs=0.
REQ-024 Wait counter clears in IDLE, increments each WAIT cycle, saturates at all-ones.
REQ-025 STAB (cause[1]): in WAIT or STALL, any change of adr, we, sel, or (we=1) dat_w versus previous cycle while cs=1.
REQ-026 SPUR (cause[2]): ack or err asserted while cs=0.
REQ-027 Violations only detected when enable=1; cause bits sticky until clr or rst.
REQ-028 clr zeroes cause and all counters; a violation or count in the same cycle as clr takes effect (applied after clear); clr does not flush FIFO.
REQ-029 Latency: counters and cause update one cycle after the triggering edge; trc_valid rises two cycles after trn into empty FIFO.

Reset
REQ-030 rst clears FSM to IDLE, wait counter, counters, cause, error, FIFO pointers, trc_level, trc_valid, pending-push register; FIFO storage not reset.
REQ-031 rst mid-transfer discards the pending push; first post-reset trn is handled normally.

Structure
REQ-032 Shared qmem package holds FSM state encoding and cause bit index constants (CAUSE_TMO=0, CAUSE_STAB=1, CAUSE_SPUR=2, CAUSE_OVF=3).
REQ-033 Trace storage is one sub-module qmem_trc_fifo (synchronous FWFT FIFO, width 2+QSW+QAW+QDW, depth 2**TRC_AW).

Verification
REQ-034 Write adr 0x100 sel F dat 0xDEADBEEF ack same cycle -> w_cnt=1, trace head {we=1,adr=0x100,dat=0xDEADBEEF}, error=0.
REQ-035 Read adr 0x200, dat_r=0x12345678 at ack+1 -> r_cnt=1, trace dat=0x12345678.
REQ-036 tmo_lim=4, cs held 10 cycles no ack -> cause=0x1 after 4th wait cycle; tmo_lim=0 repeat -> no TMO.
REQ-037 adr changed 0x10->0x14 mid-WAIT -> cause[1]=1; ack with cs=0 -> cause[2]=1; clr -> cause=0, counters 0.
REQ-038 TRC_AW=2, 5 back-to-back writes, no pop -> level=4, OVF set, head = first write; pop+push when full -> level stays 4.
